// File: rtl/mem_resp_pkg.sv
// Shared definitions for the two-port memory responder: the per-port FSM
// state encoding and the default geometry and latency.
package mem_resp_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_LATENCY   = 2;

  // Wide enough for the largest legal LATENCY-1 (14).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_port.sv
// One responder port: request acceptance, latency down-counter, address/data
// capture and the one-cycle ack. It tells the top level on which edge the
// memory access happens (fire) and which address/data to use.
// MEM_RESP_ERR_EN enables the sticky protocol-error flag.
module mem_resp_port
  import mem_resp_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 fire,
  output logic                 fire_wr,
  output logic [WORD_SIZE-1:0] fire_addr,
  output logic [WORD_SIZE-1:0] fire_data,
  output logic                 ack,
  output logic                 err
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 op_wr;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 accept;
  logic                 held;

  // Access strobe for the edge that enters RESP. With LATENCY=1 that is the
  // accepting edge itself, so the live inputs are forwarded instead of the
  // captured copies. Gated by reset_n so a write never commits under reset.
  always_comb begin
    accept    = (state == IDLE) && (rd_req ^ wr_req);
    held      = op_wr ? wr_req : rd_req;
    fire      = 1'b0;
    fire_wr   = op_wr;
    fire_addr = addr_q;
    fire_data = data_q;
    if (state == IDLE) begin
      fire      = reset_n && accept && (LATENCY == 1);
      fire_wr   = wr_req;
      fire_addr = addr;
      fire_data = wdata;
    end else if (state == WAIT) begin
      fire = reset_n && held && (cnt == '0);
    end
  end

  // Port FSM: accept, count down the latency, pulse ack, abort on a dropped request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_wr  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ack    <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= addr;
            op_wr  <= wr_req;
            if (wr_req) data_q <= wdata;
            cnt <= CNT_W'(LATENCY - 1);
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state <= RESP;
              ack   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!held) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= RESP;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic drop;
  assign drop = (state == WAIT) && !held;

  // Sticky error: read+write together in IDLE, or a request dropped mid-wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else if (((state == IDLE) && rd_req && wr_req) || drop) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/mem_port_responder.sv
// Two-port memory responder: an instruction read port and a data read/write
// port, each answering after a fixed latency. Holds the memory array, the
// read data registers and the data2 tristate driver.
// MEM_RESP_ERR_EN enables the sticky protocol-error flag on err.
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 ack1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 ack2,
  output logic                 err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

  logic                 p1_fire, p1_fire_wr, p1_err;
  logic                 p2_fire, p2_fire_wr, p2_err;
  logic [WORD_SIZE-1:0] p1_addr, p1_data, p2_addr, p2_data;
  logic [AW-1:0]        idx1, idx2;
  logic [WORD_SIZE-1:0] rdata2;
  logic                 drive2;

  mem_resp_port #(.WORD_SIZE(WORD_SIZE), .LATENCY(LATENCY)) u_port1 (
    .clk(clk), .reset_n(reset_n),
    .rd_req(readM1), .wr_req(1'b0), .addr(address1), .wdata('0),
    .fire(p1_fire), .fire_wr(p1_fire_wr), .fire_addr(p1_addr), .fire_data(p1_data),
    .ack(ack1), .err(p1_err)
  );

  mem_resp_port #(.WORD_SIZE(WORD_SIZE), .LATENCY(LATENCY)) u_port2 (
    .clk(clk), .reset_n(reset_n),
    .rd_req(readM2), .wr_req(writeM2), .addr(address2), .wdata(data2),
    .fire(p2_fire), .fire_wr(p2_fire_wr), .fire_addr(p2_addr), .fire_data(p2_data),
    .ack(ack2), .err(p2_err)
  );

  // Word index: address taken modulo the memory depth.
  always_comb begin
    idx1 = AW'(p1_addr % MEM_DEPTH);
    idx2 = AW'(p2_addr % MEM_DEPTH);
  end

  // Memory commit, never reset. Port 1 shares the commit path but its write
  // request is tied low, so that branch folds away.
  always_ff @(posedge clk) begin
    if (p2_fire && p2_fire_wr) mem[idx2] <= p2_data;
    if (p1_fire && p1_fire_wr) mem[idx1] <= p1_data;
  end

  // Read data registers; a same-edge write is not visible here, so a
  // colliding port-1 read returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data1  <= '0;
      rdata2 <= '0;
      drive2 <= 1'b0;
    end else begin
      drive2 <= p2_fire && !p2_fire_wr;
      if (p1_fire && !p1_fire_wr) data1  <= mem[idx1];
      if (p2_fire && !p2_fire_wr) rdata2 <= mem[idx2];
    end
  end

  assign data2 = drive2 ? rdata2 : 'z;
  assign err   = p1_err | p2_err;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: three instances with LATENCY 1, 2, 3 driven
// one transaction at a time against a word-array reference model.
// data2 is probed by keeping the bench driving a known value whenever the
// responder must stay off the bus; any responder drive corrupts that value.
module tb_mem_port_responder;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        readM1   [N];
  logic        readM2   [N];
  logic        writeM2  [N];
  logic [15:0] address1 [N];
  logic [15:0] address2 [N];
  logic [15:0] data1    [N];
  logic        ack1     [N];
  logic        ack2     [N];
  logic        err      [N];
  logic [15:0] d2_drv   [N];
  logic        d2_en    [N];
  logic [15:0] d2_obs   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [15:0] bus;
    assign bus = d2_en[g] ? d2_drv[g] : 16'bz;
    assign d2_obs[g] = bus;
    mem_port_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(g + 1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .readM1(readM1[g]), .address1(address1[g]), .data1(data1[g]), .ack1(ack1[g]),
      .readM2(readM2[g]), .writeM2(writeM2[g]), .address2(address2[g]),
      .data2(bus), .ack2(ack2[g]), .err(err[g])
    );
  end

  // Reference model
  logic [15:0] mem_m  [N][256];
  logic [15:0] data1_m[N];
  logic        err_m  [N];

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc_check(input int i, input bit a1, input bit a2);
    check($sformatf("ack1[%0d]", i), 16'(ack1[i]), 16'(a1));
    check($sformatf("ack2[%0d]", i), 16'(ack2[i]), 16'(a2));
    check($sformatf("data1[%0d]", i), data1[i], data1_m[i]);
    check($sformatf("err[%0d]", i), 16'(err[i]), 16'(err_m[i]));
    if (d2_en[i]) check($sformatf("data2_hiz[%0d]", i), d2_obs[i], d2_drv[i]);
  endtask

  task automatic release_req(input int i);
    readM1[i]  = 1'b0;
    readM2[i]  = 1'b0;
    writeM2[i] = 1'b0;
    d2_en[i]   = 1'b1;
    d2_drv[i]  = 16'h0000;
  endtask

  // One transaction on one port. Response expected in the cycle after the
  // accepting edge for LATENCY=1, otherwise after edge t0+LATENCY.
  // drop_at>0 drops the request at that negedge (inside the wait window).
  task automatic run_txn(input int i, input bit p2, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int drop_at);
    int lat, k_exp, idx;
    lat   = i + 1;
    k_exp = (lat == 1) ? 1 : lat + 1;
    idx   = int'(addr) % 256;
    if (!p2) begin
      readM1[i] = 1'b1; address1[i] = addr;
    end else begin
      readM2[i] = !wr; writeM2[i] = wr; address2[i] = addr;
      d2_drv[i] = wr ? wd : 16'h0000;
      d2_en[i]  = !(!wr && k_exp == 1);
    end
    for (int k = 1; k <= k_exp; k++) begin
      @(negedge clk);
      if (k < k_exp) begin
        cyc_check(i, 1'b0, 1'b0);
        if (drop_at == k) begin
          release_req(i);
`ifdef MEM_RESP_ERR_EN
          err_m[i] = 1'b1;
`endif
          repeat (lat + 1) begin
            @(negedge clk);
            cyc_check(i, 1'b0, 1'b0);
          end
          return;
        end
        // captured values must win over anything presented during the wait
        if (p2) begin
          address2[i] = 16'($urandom);
          if (wr) d2_drv[i] = 16'($urandom);
        end else begin
          address1[i] = 16'($urandom);
        end
        if (p2 && !wr && k + 1 == k_exp) d2_en[i] = 1'b0;
      end else begin
        if (!p2) data1_m[i] = mem_m[i][idx];
        else if (wr) mem_m[i][idx] = wd;
        cyc_check(i, !p2, p2);
        if (p2 && !wr) check($sformatf("data2_read[%0d]", i), d2_obs[i], mem_m[i][idx]);
        release_req(i);
      end
    end
    @(negedge clk);
    cyc_check(i, 1'b0, 1'b0);
  endtask

  // readM2 and writeM2 together: never accepted.
  task automatic both_high(input int i, input logic [15:0] addr, input logic [15:0] wd);
    readM2[i] = 1'b1; writeM2[i] = 1'b1; address2[i] = addr; d2_drv[i] = wd;
`ifdef MEM_RESP_ERR_EN
    err_m[i] = 1'b1;
`endif
    repeat (4) begin
      @(negedge clk);
      cyc_check(i, 1'b0, 1'b0);
    end
    release_req(i);
    @(negedge clk);
    cyc_check(i, 1'b0, 1'b0);
  endtask

  // Port-1 read and port-2 write of the same word accepted on the same edge.
  task automatic same_edge(input int i, input logic [15:0] addr, input logic [15:0] wd);
    int lat, k_exp, idx;
    lat   = i + 1;
    k_exp = (lat == 1) ? 1 : lat + 1;
    idx   = int'(addr) % 256;
    readM1[i] = 1'b1; address1[i] = addr;
    writeM2[i] = 1'b1; address2[i] = addr; d2_drv[i] = wd;
    for (int k = 1; k < k_exp; k++) begin
      @(negedge clk);
      cyc_check(i, 1'b0, 1'b0);
    end
    @(negedge clk);
    data1_m[i] = mem_m[i][idx];
    mem_m[i][idx] = wd;
    cyc_check(i, 1'b1, 1'b1);
    release_req(i);
    @(negedge clk);
    cyc_check(i, 1'b0, 1'b0);
  endtask

  // Reset pulsed while a write waits: nothing committed, outputs cleared.
  task automatic reset_mid_wait(input int i, input logic [15:0] addr, input logic [15:0] wd);
    writeM2[i] = 1'b1; address2[i] = addr; d2_drv[i] = wd;
    @(negedge clk);
    cyc_check(i, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    for (int j = 0; j < N; j++) begin
      data1_m[j] = 16'h0000;
      err_m[j]   = 1'b0;
      cyc_check(j, 1'b0, 1'b0);
    end
    release_req(i);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cyc_check(i, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    for (int i = 0; i < N; i++) begin
      readM1[i] = 1'b0; readM2[i] = 1'b0; writeM2[i] = 1'b0;
      address1[i] = 16'h0000; address2[i] = 16'h0000;
      d2_en[i] = 1'b1; d2_drv[i] = 16'h0000;
      data1_m[i] = 16'h0000; err_m[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) cyc_check(i, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) cyc_check(i, 1'b0, 1'b0);

    // give every pool word a known value
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 16; a++)
        run_txn(i, 1'b1, 1'b1, 16'(a), 16'($urandom), 0);

    // LATENCY=2 basics
    run_txn(1, 1'b1, 1'b1, 16'h0005, 16'h1234, 0);
    run_txn(1, 1'b0, 1'b0, 16'h0005, 16'h0000, 0);
    run_txn(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 0);
    run_txn(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 0);

    // LATENCY=3 aborts: read dropped after one wait cycle, write dropped
    run_txn(2, 1'b1, 1'b0, 16'h0003, 16'h0000, 2);
    run_txn(2, 1'b1, 1'b1, 16'h0004, 16'hDEAD, 1);
    run_txn(2, 1'b1, 1'b0, 16'h0004, 16'h0000, 0);

    // read+write together is a no-op
    both_high(1, 16'h0006, 16'hCAFE);
    run_txn(1, 1'b1, 1'b0, 16'h0006, 16'h0000, 0);

    // same-edge read/write collision returns old data
    run_txn(1, 1'b1, 1'b1, 16'h0007, 16'h0001, 0);
    same_edge(1, 16'h0007, 16'h00FF);
    run_txn(1, 1'b1, 1'b0, 16'h0007, 16'h0000, 0);
    run_txn(1, 1'b0, 1'b0, 16'h0007, 16'h0000, 0);

    // reset during a pending write, then LATENCY=1 and LATENCY=3 read-back
    reset_mid_wait(2, 16'h0003, 16'h5555);
    run_txn(2, 1'b1, 1'b0, 16'h0003, 16'h0000, 0);
    run_txn(0, 1'b1, 1'b1, 16'h0009, 16'hA5A5, 0);
    run_txn(0, 1'b0, 1'b0, 16'h0109, 16'h0000, 0);

    // randomized traffic; upper address bits exercise the modulo wrap
    for (int i = 0; i < N; i++) begin
      for (int n = 0; n < 40; n++) begin
        bit          p2, wr;
        int          drop;
        logic [15:0] a;
        p2   = ($urandom_range(0, 1) == 1);
        wr   = p2 && ($urandom_range(0, 1) == 1);
        a    = 16'($urandom_range(0, 15) + 256 * $urandom_range(0, 255));
        drop = 0;
        if (i > 0 && $urandom_range(0, 4) == 0) drop = int'($urandom_range(1, i));
        run_txn(i, p2, wr, a, 16'($urandom), drop);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning address/data width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 256, meaning number of words; address taken modulo MEM_DEPTH.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-004 The block SHALL have a single clock, clk, and an asynchronous, active-low reset, reset_n: `clk  in  1  clock`, then `reset_n  in  1  asynchronous active-low reset`.
REQ-005 readM1  in  1  instruction-port read request.
REQ-006 address1  in  WORD_SIZE  instruction address.
REQ-007 data1  out  WORD_SIZE  instruction read data.
REQ-008 ack1  out  1  instruction response valid, one-cycle pulse.
REQ-009 readM2  in  1  data-port read request.
REQ-010 writeM2  in  1  data-port write request.
REQ-011 address2  in  WORD_SIZE  data address.
REQ-012 data2  inout  WORD_SIZE  write data in; read data out when driven.
REQ-013 ack2  out  1  data response/write-done, one-cycle pulse.
REQ-014 err  out  1  sticky protocol-error flag.

Function
REQ-015 Each port SHALL run an independent FSM with states IDLE, WAIT, and RESP.
REQ-016 In IDLE, a request sampled high at a clk edge SHALL be accepted: address captured, for port 2 the operation captured, and for a write data2 captured; the down-counter is loaded with LATENCY-1.
REQ-017 The FSM SHALL go IDLE->WAIT if LATENCY>1, else IDLE->RESP; WAIT->RESP when the counter reaches 0, decrementing once per cycle otherwise.
REQ-018 Entering RESP, a read SHALL register mem[addr] into data1 or its data-port holding register; a write SHALL commit the captured data to mem[addr] at that same edge.
REQ-019 ack1/ack2 SHALL be high exactly during the RESP cycle, i.e. the cycle after edge t0+LATENCY, where t0 is the accepting edge.
REQ-020 RESP->IDLE SHALL be unconditional; a request still high in IDLE SHALL be a new request.
REQ-021 If the request drops during WAIT, the FSM SHALL abort to IDLE with no ack, and a write SHALL NOT be committed.
REQ-022 data2 SHALL be driven only in a port-2 read RESP cycle, and SHALL be high-Z at all other times.
REQ-023 data1 SHALL hold its last value outside RESP.
REQ-024 readM2 and writeM2 both high in IDLE SHALL be treated as a no-op: not accepted, no ack.
REQ-025 A port-1 read and a port-2 write to the same address entering RESP on the same edge SHALL return the old data to port 1.
REQ-026 Address and data changes during WAIT SHALL be ignored, because the captured values are used.

Reset
REQ-027 While reset_n is low: both FSMs IDLE, counters 0, ack1=ack2=0, data1=0, data2 high-Z, err=0.
REQ-028 Reset asserted mid-WAIT or mid-RESP SHALL abort without committing a pending write.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro MEM_RESP_ERR_EN: when defined, err SHALL set on simultaneous readM2/writeM2 in IDLE, or on a request drop during WAIT, and clear only on reset.
REQ-031 When MEM_RESP_ERR_EN is undefined, err SHALL be tied to 0 and the error logic SHALL be absent.

Structure
REQ-032 Shared package mem_resp_pkg SHALL hold the state encoding (IDLE/WAIT/RESP) and the default WORD_SIZE, MEM_DEPTH and LATENCY constants.
REQ-033 Sub-module mem_resp_port (FSM, counter, capture registers, ack) SHALL be instantiated twice; the memory array and data2 tristate SHALL stay in the top level.

Verification
REQ-034 LATENCY=2; reset, then readM1=1, address1=0x0005 with mem[5]=0x1234 -> ack1 high in the cycle after the 2nd edge following acceptance, data1=0x1234.
REQ-035 writeM2=1, address2=0x0010, data2=0xBEEF held until ack2; then readM2=1, address2=0x0010 -> ack2 pulse with data2 driven 0xBEEF for exactly that cycle, high-Z otherwise.
REQ-036 LATENCY=3; readM2 dropped after 1 cycle of WAIT -> no ack2, FSM returns to IDLE; with MEM_RESP_ERR_EN, err=1 and stays 1.
REQ-037 readM2=writeM2=1 -> no ack2, memory unchanged; err=1 only if MEM_RESP_ERR_EN is defined.
REQ-038 mem[7]=0x0001; port-1 read addr 7 and port-2 write 0x00FF to addr 7 accepted on the same edge -> data1=0x0001, and a later read of addr 7 returns 0x00FF.
REQ-039 reset_n pulsed low during a write's WAIT -> acks 0, data2 high-Z, target word unchanged; with LATENCY=1, ack arrives the cycle after acceptance.
